// File: rtl/checker_ctlif_block.sv
// CSR control interface for the memory checker: address/mode/start registers,
// status readback and an end-of-check interrupt pulse.
module checker_ctlif_block #(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic [1:0]  cmode,
    output logic        cstart,
    output logic [63:0] caddr,
    input  logic        cend,
    input  logic [7:0]  cctrl
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 10;
    localparam int unsigned BANK_W = 4;

    localparam logic [OFF_W-1:0] OFF_CTRL    = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_ADDR_LO = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_ADDR_HI = OFF_W'(2);

    logic [DATA_W-1:0] addr_lo;
    logic [DATA_W-1:0] addr_hi;
    logic              irq_en;
    logic [1:0]        mode;
    logic              start;

    logic              csr_sel_c;
    logic [OFF_W-1:0]  csr_off_c;
    logic              ctrl_wr_c;
    logic              cend_hit_c;
    logic [DATA_W-1:0] rd_data_c;

    assign csr_sel_c  = (csr_a[13:13-BANK_W+1] == csr_addr);
    assign csr_off_c  = csr_a[OFF_W-1:0];
    assign ctrl_wr_c  = csr_sel_c && csr_we && (csr_off_c == OFF_CTRL);
    // cend only counts while a check is actually running
    assign cend_hit_c = cend && start;

    // Read mux over the pre-write register state
    always_comb begin
        rd_data_c = '0;
        case (csr_off_c)
            OFF_CTRL:    rd_data_c = {16'h0000, cctrl, 4'h0, start, mode, irq_en};
            OFF_ADDR_LO: rd_data_c = addr_lo;
            OFF_ADDR_HI: rd_data_c = addr_hi;
            default:     rd_data_c = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_lo <= '0;
            addr_hi <= '0;
            irq_en  <= 1'b0;
            mode    <= 2'b00;
            start   <= 1'b0;
            irq     <= 1'b0;
            csr_do  <= '0;
        end else begin
            csr_do <= csr_sel_c ? rd_data_c : '0;
            // irq uses the pre-write irq_en so a same-cycle write cannot cancel it
            irq    <= cend_hit_c && irq_en;

            if (cend_hit_c) begin
                start <= 1'b0;
            end

            if (csr_sel_c && csr_we) begin
                case (csr_off_c)
                    OFF_CTRL: begin
                        irq_en <= csr_di[0];
                        mode   <= csr_di[2:1];
                        start  <= csr_di[3];
                    end
                    OFF_ADDR_LO: addr_lo <= csr_di;
                    OFF_ADDR_HI: addr_hi <= csr_di;
                    default: ;
                endcase
            end
        end
    end

    assign cmode  = mode;
    assign cstart = start;
    assign caddr  = {addr_hi, addr_lo};

endmodule

// File: tb/tb_checker_ctlif_block.sv
// Bench for checker_ctlif_block: directed scenarios then randomized CSR/cend
// traffic, all compared against a cycle-level reference model.
module tb_checker_ctlif_block;

    localparam logic [3:0] BANK = 4'h3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [1:0]  cmode;
    logic        cstart;
    logic [63:0] caddr;
    logic        cend;
    logic [7:0]  cctrl;

    checker_ctlif_block #(.csr_addr(BANK)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .irq(irq), .cmode(cmode),
        .cstart(cstart), .caddr(caddr), .cend(cend), .cctrl(cctrl)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_lo, m_hi, m_do;
    logic        m_irq_en, m_start, m_irq;
    logic [1:0]  m_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge as the spec describes it, from the inputs applied now
    task automatic model_step();
        logic        sel;
        int unsigned off;
        logic        fire;
        if (sys_rst) begin
            m_lo = 0; m_hi = 0; m_irq_en = 0; m_mode = 0; m_start = 0;
            m_irq = 0; m_do = 0;
            return;
        end
        sel  = (csr_a[13:10] == BANK);
        off  = 32'(csr_a[9:0]);
        m_do = 0;
        if (sel) begin
            if (off == 0)      m_do = 32'(cctrl) * 256 + 32'(m_start) * 8 + 32'(m_mode) * 2 + 32'(m_irq_en);
            else if (off == 1) m_do = m_lo;
            else if (off == 2) m_do = m_hi;
        end
        fire  = m_start && cend;
        m_irq = fire && m_irq_en;
        if (fire) m_start = 0;
        if (sel && csr_we) begin
            if (off == 0) begin
                m_irq_en = csr_di[0];
                m_mode   = csr_di[2:1];
                m_start  = csr_di[3];
            end else if (off == 1) m_lo = csr_di;
            else if (off == 2)     m_hi = csr_di;
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        model_step();
        #1;
        check("csr_do", 64'(csr_do), 64'(m_do));
        check("irq",    64'(irq),    64'(m_irq));
        check("cmode",  64'(cmode),  64'(m_mode));
        check("cstart", 64'(cstart), 64'(m_start));
        check("caddr",  caddr,       {m_hi, m_lo});
        sys_rst = 1'b0; csr_we = 1'b0; cend = 1'b0;
        csr_a   = 14'h3fff;
    endtask

    task automatic wr(input logic [3:0] bank, input logic [9:0] off, input logic [31:0] d);
        csr_a = {bank, off}; csr_we = 1'b1; csr_di = d;
        cyc();
    endtask

    task automatic rd(input logic [9:0] off);
        csr_a = {BANK, off}; csr_we = 1'b0;
        cyc();
    endtask

    initial begin
        sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0; cend = 1'b0; cctrl = 8'h00;
        m_lo = 0; m_hi = 0; m_do = 0; m_irq_en = 0; m_start = 0; m_irq = 0; m_mode = 0;

        // Reset state
        sys_rst = 1'b1;
        cyc();
        check("rst_caddr", caddr, 64'h0);
        check("rst_cstart", 64'(cstart), 64'h0);
        check("rst_do", 64'(csr_do), 64'h0);

        // Address round-trip
        wr(BANK, 10'd1, 32'haaaaaaaa);
        wr(BANK, 10'd2, 32'hbbbbbbbb);
        rd(10'd1);
        check("rt_lo", 64'(csr_do), 64'haaaaaaaa);
        rd(10'd2);
        check("rt_hi", 64'(csr_do), 64'hbbbbbbbb);
        check("rt_caddr", caddr, 64'hbbbbbbbbaaaaaaaa);

        // Start then cend with irq enabled
        wr(BANK, 10'd0, 32'h9);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("run_cstart", 64'(cstart), 64'h1);
        end
        cend = 1'b1;
        cyc();
        check("end_cstart", 64'(cstart), 64'h0);
        check("end_irq", 64'(irq), 64'h1);
        cyc();
        check("end_irq_off", 64'(irq), 64'h0);
        rd(10'd0);
        check("end_ctrl", 64'(csr_do), 64'h1);

        // cend while idle is ignored
        cend = 1'b1;
        cyc();
        check("idle_irq", 64'(irq), 64'h0);

        // User abort
        wr(BANK, 10'd0, 32'h9);
        for (int i = 0; i < 10; i++) cyc();
        wr(BANK, 10'd0, 32'h1);
        check("abort_cstart", 64'(cstart), 64'h0);
        check("abort_irq", 64'(irq), 64'h0);
        cyc();
        check("abort_irq2", 64'(irq), 64'h0);

        // Same-cycle CTRL write and cend: write wins, irq from old irq_en
        wr(BANK, 10'd0, 32'hf);
        cend = 1'b1;
        wr(BANK, 10'd0, 32'h2);
        check("race_irq", 64'(irq), 64'h1);
        check("race_mode", 64'(cmode), 64'h1);
        check("race_cstart", 64'(cstart), 64'h0);

        // Status readback
        wr(BANK, 10'd0, 32'h1);
        cctrl = 8'h5a;
        rd(10'd0);
        check("status", 64'(csr_do), 64'h5a01);

        // Reset mid-run, colliding with a write and cend
        wr(BANK, 10'd0, 32'h9);
        sys_rst = 1'b1; cend = 1'b1;
        csr_a = {BANK, 10'd1}; csr_we = 1'b1; csr_di = 32'h12345678;
        cyc();
        check("mrst_cstart", 64'(cstart), 64'h0);
        check("mrst_caddr", caddr, 64'h0);
        check("mrst_irq", 64'(irq), 64'h0);
        cyc();
        check("mrst_irq2", 64'(irq), 64'h0);
        rd(10'd1);
        check("mrst_lo", 64'(csr_do), 64'h0);

        // Bank mismatch
        wr(4'h5, 10'd1, 32'hdeadbeef);
        check("bank_do", 64'(csr_do), 64'h0);
        check("bank_caddr", caddr, 64'h0);
        csr_a = {4'h5, 10'd0};
        cyc();
        check("bank_rd", 64'(csr_do), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] bank;
            bank    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : BANK;
            csr_a   = {bank, 10'($urandom_range(0, 4))};
            csr_we  = 1'($urandom_range(0, 1));
            csr_di  = $urandom;
            cend    = ($urandom_range(0, 3) == 0);
            cctrl   = 8'($urandom);
            sys_rst = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
